extend_pipe: RTL and testbench

//  Parametrised, pipelined width extender with per-transaction extension mode.

---
 rtl/extend_pipe.sv | 164 ++++++++++++++++
 tb/tb_extend_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/extend_pipe.sv
// Purpose  : pipelined IN_W->OUT_W width extender (zero / sign / one-fill / sign-then-shift).
// Latency  : 1 cycle from accept to out_valid, 1 transfer per cycle sustained.
// Backpress: 2-entry skid (output reg + skid reg); in_ready is registered, with no comb path from out_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_data (IN_W) and in_mode (2) sampled on accept
//   out_valid/out_ready  downstream handshake; out_data (OUT_W) held stable while stalled
//   xfer_cnt (16)        saturating accepted-transaction count, present only when EXT_PERF_EN is defined
//
// Optional feature macro: EXT_PERF_EN (adds xfer_cnt port and counter).
// Mode encoding: 00 zero-fill, 01 sign-extend, 10 one-fill, 11 sign-extend then << SHIFT.

module extend_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef EXT_PERF_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  // Guarded so an illegal configuration reaches the elaboration error below
  // instead of failing earlier on a zero-width replication.
  localparam int PAD_W = (OUT_W > IN_W) ? (OUT_W - IN_W) : 1;

  if (OUT_W <= IN_W) begin : g_bad_width
    $error("extend_pipe: OUT_W (%0d) must exceed IN_W (%0d)", OUT_W, IN_W);
  end
  if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
    $error("extend_pipe: SHIFT (%0d) must be in 0..OUT_W-1", SHIFT);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [OUT_W-1:0]   r_skid_data;

  logic               w_acc;
  logic               w_emit;
  logic               w_load_out;
  logic               w_load_skid;
  logic               w_out_from_skid;
  logic [OUT_W-1:0]   w_sext;
  logic [OUT_W-1:0]   w_ext;

  assign w_acc  = in_valid & r_in_ready;
  assign w_emit = r_out_valid & out_ready;

  // Extension of the field currently on the input; only captured on accept.
  always_comb begin
    w_sext = {{PAD_W{in_data[IN_W-1]}}, in_data};
    w_ext  = w_sext;
    case (in_mode)
      2'b00:   w_ext = {{PAD_W{1'b0}}, in_data};
      2'b01:   w_ext = w_sext;
      2'b10:   w_ext = {{PAD_W{1'b1}}, in_data};
      default: w_ext = w_sext << SHIFT;
    endcase
  end

  // Occupancy FSM: next state and data-register steering.
  always_comb begin
    w_next          = r_state;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_next     = ONE;
          w_load_out = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && w_emit) begin
          w_load_out = 1'b1;
        end else if (w_acc) begin
          w_next      = TWO;
          w_load_skid = 1'b1;
        end else if (w_emit) begin
          w_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (w_emit) begin
          w_next          = ONE;
          w_out_from_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so neither output
  // depends combinationally on out_ready or in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != TWO);
      r_out_valid <= (w_next != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out) begin
        r_out_data <= w_ext;
      end else if (w_out_from_skid) begin
        r_out_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= w_ext;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef EXT_PERF_EN
  logic [15:0] r_xfer_cnt;

  // Saturating count of accepted transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= 16'h0000;
    end else if (w_acc && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_extend_pipe.sv
// Purpose  : directed self-checking bench for extend_pipe (IN_W=4, OUT_W=8, SHIFT=2).
// Latency  : inputs driven 1 time unit after posedge, outputs sampled 1 time unit after posedge.
// Backpress: exercises full-rate streaming, skid fill/drain under out_ready=0, and reset in TWO.

module tb_extend_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef EXT_PERF_EN
  logic [15:0] xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;

  extend_pipe #(.IN_W(4), .OUT_W(8), .SHIFT(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef EXT_PERF_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-beat vectors: data, mode, hand-computed result.
  logic [3:0] sv_d[9] = '{4'hA, 4'hA, 4'h5, 4'h3, 4'h8, 4'h7, 4'hF, 4'h0, 4'hF};
  logic [1:0] sv_m[9] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11};
  logic [7:0] sv_e[9] = '{8'h0A, 8'hFA, 8'h05, 8'hF3, 8'hE0, 8'h1C, 8'hFF, 8'hF0, 8'hFC};

  // Streaming beats, all sign-extended.
  logic [3:0] st_d[8] = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
  logic [7:0] st_e[8] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'hF9, 8'hFB, 8'hFD, 8'hFF};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_mode   = 2'b00;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  {24'd0, out_data},  32'h00);
`ifdef EXT_PERF_EN
    chk("rst_xfer_cnt",  {16'd0, xfer_cnt},  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single beats through an otherwise idle pipe.
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      in_data   = sv_d[i];
      in_mode   = sv_m[i];
      out_ready = 1'b1;
      tick();
      // Scramble inputs after accept; the captured result must not follow.
      in_valid = 1'b0;
      in_data  = ~sv_d[i];
      in_mode  = ~sv_m[i];
      chk($sformatf("single%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("single%0d_data", i),  {24'd0, out_data},  {24'd0, sv_e[i]});
      tick();
      chk($sformatf("single%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Full-rate stream: one result per cycle, each one cycle after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = st_d[i];
      in_mode  = 2'b01;
      tick();
      chk($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_data", i),  {24'd0, out_data},  {24'd0, st_e[i]});
      chk($sformatf("stream%0d_ready", i), {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three beats offered while downstream stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 4'h1;
    tick();
    chk("bp_b0_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_b0_data",  {24'd0, out_data},  32'h01);
    chk("bp_b0_ready", {31'd0, in_ready},  32'd1);
    in_data = 4'h2;
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_full_data",  {24'd0, out_data}, 32'h01);
    in_data = 4'h3;
    tick();
    chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_data",  {24'd0, out_data},  32'h01);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_data",  {24'd0, out_data}, 32'h02);
    chk("bp_drain1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_drain2_data",  {24'd0, out_data},  32'h03);
    chk("bp_drain2_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

    // Reset while the skid is full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b10;
    in_data   = 4'h4;
    tick();
    in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    chk("mid_two_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_data",  {24'd0, out_data},  32'h00);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_post%0d_valid", i), {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_mode  = 2'b11;
    in_data  = 4'h7;
    tick();
    in_valid = 1'b0;
    chk("mid_after_data",  {24'd0, out_data},  32'h1C);
    chk("mid_after_valid", {31'd0, out_valid}, 32'd1);
    tick();

`ifdef EXT_PERF_EN
    // Saturation, with the first accept landing on the reset-release edge.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 4'h1;
    out_ready = 1'b1;
    #1;
    chk("perf_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("perf_first_cnt", {16'd0, xfer_cnt}, 32'd1);
    repeat (69999) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("perf_sat_cnt", {16'd0, xfer_cnt}, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("perf_clr_cnt", {16'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
